my_dmux8way16_collect: RTL and testbench
========================================

// Module: my_dmux8way16_collect
// PURPOSE
// - Receive side of the 8-way 16-bit lane mux: accepts one 16-bit word per handshake,
//   tagged with a 3-bit lane select, and steers it into one of 8 registered lanes.
// - Once all 8 lanes are filled, or a word marked last arrives, it presents the
//   collected frame on a valid/ready output handshake.
// - Sits downstream of a my_mux8way16-driven link and rebuilds the 8 parallel words.
// PARAMETERS
// - WIDTH   16  lane/data width in bits (shortint lanes)
// - CNT_W   8   width of frame counter; wraps modulo 2**CNT_W
// PORTS
// clk        input   1      rising-edge clock
// rst_n      input   1      asynchronous active-low reset
// in_valid   input   1      in_data/in_sel/in_last valid
// in_ready   output  1      block can accept a word this cycle
// in_data    input   WIDTH  word to store
// in_sel     input   3      destination lane 0..7
// in_last    input   1      close the frame after this word
// out_valid  output  1      frame held on out0..out7/out_mask
// out_ready  input   1      consumer takes frame
// out0..out7 output  WIDTH  lane registers
// out_mask   output  8      bit i = lane i written in this frame
// out_dup    output  1      1-cycle pulse: accepted word hit an already-written lane
// frame_cnt  output  CNT_W  frames released since reset
// BEHAVIOUR
// - Reset (async, rst_n=0): state=FILL, out0..out7=0, out_mask=0, out_valid=0,
//   out_dup=0, frame_cnt=0; in_ready=1 from first clock after release.
// - States: FILL (collecting), HOLD (frame presented). in_ready=(state==FILL);
//   out_valid=(state==HOLD). Both are registered-state decodes; no input combinational path.
// - Accept = in_valid & in_ready. On accept at edge: out[in_sel]<=in_data;
//   out_mask[in_sel]<=1; out_dup<=out_mask[in_sel] (else out_dup<=0 every cycle).
// - FILL->HOLD at the accept edge if (out_mask | onehot(in_sel))==8'hFF or in_last=1.
//   Latency: frame visible (out_valid=1) the cycle after the closing accept.
// - Duplicate lane write: data overwritten (last write wins), mask unchanged, out_dup pulses,
//   frame does not close unless the fill/last rule holds.
// - in_last on the first word: frame closes with single-bit mask.
// - HOLD: lane registers and mask are frozen; in_data ignored. out_valid stays high
//   until out_ready; out_valid must not drop without out_ready.
// - HOLD & out_ready at edge: state<=FILL, out_mask<=0, frame_cnt<=frame_cnt+1
//   (wraps 2**CNT_W-1 -> 0). Lane data is NOT cleared; stale values remain visible but
//   are excluded by out_mask.
// - No same-cycle release-and-accept: in_ready is 0 in the release cycle; next word
//   is accepted at the earliest one cycle later (max throughput: 1 frame per N+1 cycles).
// - in_valid while in_ready=0: no effect; sender must hold data (standard valid/ready).
// - rst_n asserted mid-frame or in HOLD: immediate return to reset values; partial
//   frame discarded, frame_cnt cleared.
// TESTING
// - Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0, in_ready=1 after release.
// - Full frame: sel 0..7 with data 16'h1000+i, back-to-back -> out_valid next cycle,
//   outN=16'h1000+N, out_mask=8'hFF, in_ready=0; out_ready=1 -> frame_cnt=1, mask=0.
// - Early last: sel=3 data 16'hBEEF, sel=5 data 16'h1234 last=1 -> out_mask=8'h28,
//   out3=16'hBEEF, out5=16'h1234; in_valid held in HOLD changes nothing.
// - Duplicate: sel=2 16'hAAAA then sel=2 16'h5555 -> out2=16'h5555, out_dup=1 for 1
//   cycle, out_mask=8'h04, state stays FILL.
// - Backpressure: frame held with out_ready=0 for 10 cycles -> outputs stable, out_valid=1;
//   then release -> no word accepted that cycle, accepted next.
// - Counter wrap: 256 single-word frames (last=1) -> frame_cnt returns to 0;
//   rst_n pulse during a 4-lane partial frame -> out_mask=0, frame_cnt=0.

Source files
------------

// File: rtl/my_dmux8way16_collect.sv
// Receive side of the 8-way 16-bit lane mux: steers tagged words into 8 lane registers
// and presents the collected frame on a valid/ready handshake once full or on last.
module my_dmux8way16_collect #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [7:0]       out_mask,
    output logic             out_dup,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lane_q [8];
    logic [WIDTH-1:0] lane_d [8];
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       sel_onehot;
    logic             dup_q, dup_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        sel_onehot = 8'b1 << in_sel;
        accept     = in_valid && (state_q == StFill);
        state_d    = state_q;
        lane_d     = lane_q;
        mask_d     = mask_q;
        dup_d      = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    lane_d[in_sel] = in_data;
                    mask_d         = mask_q | sel_onehot;
                    dup_d          = mask_q[in_sel];
                    if ((mask_d == 8'hFF) || in_last) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                // Lane data is kept on release; the cleared mask marks it stale.
                if (out_ready) begin
                    state_d = StFill;
                    mask_d  = 8'h00;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            for (int i = 0; i < 8; i++) begin
                lane_q[i] <= '0;
            end
            mask_q  <= 8'h00;
            dup_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            mask_q  <= mask_d;
            dup_q   <= dup_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StFill);
    assign out_valid = (state_q == StHold);
    assign out_mask  = mask_q;
    assign out_dup   = dup_q;
    assign frame_cnt = cnt_q;
    assign out0      = lane_q[0];
    assign out1      = lane_q[1];
    assign out2      = lane_q[2];
    assign out3      = lane_q[3];
    assign out4      = lane_q[4];
    assign out5      = lane_q[5];
    assign out6      = lane_q[6];
    assign out7      = lane_q[7];

endmodule

// File: tb/tb_my_dmux8way16_collect.sv
// Scoreboard bench for my_dmux8way16_collect: expected frames are queued by the stimulus
// and checked by a monitor at each output handshake.
module tb_my_dmux8way16_collect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [2:0]  in_sel = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  out_mask;
    logic        out_dup;
    logic [7:0]  frame_cnt;
    logic [15:0] outs [8];

    typedef struct packed {
        logic [7:0]       mask;
        logic [7:0]       cnt;
        logic [7:0][15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] tb_cnt = '0;

    my_dmux8way16_collect dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out_mask(out_mask), .out_dup(out_dup), .frame_cnt(frame_cnt)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(input logic [7:0] mask, input logic [7:0][15:0] data);
        exp_t e;
        e.mask = mask;
        e.cnt  = tb_cnt;
        e.data = data;
        exp_q.push_back(e);
        tb_cnt = tb_cnt + 8'd1;
    endfunction

    // Monitor: every output handshake must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_mask", {24'd0, out_mask}, {24'd0, e.mask});
                check("frame_cnt_at_release", {24'd0, frame_cnt}, {24'd0, e.cnt});
                for (int i = 0; i < 8; i++) begin
                    if (e.mask[i]) begin
                        check($sformatf("frame_lane%0d", i), {16'd0, outs[i]},
                              {16'd0, e.data[i]});
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] sel, input logic [15:0] data, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_frame();
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) check("release_timeout", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0][15:0] d;

        // Asynchronous reset asserted mid-cycle.
        #13;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_mask", {24'd0, out_mask}, 32'd0);
        check("rst_out_dup", {31'd0, out_dup}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_out%0d", i), {16'd0, outs[i]}, 32'd0);
        #8;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Full frame, back-to-back.
        for (int i = 0; i < 8; i++) d[i] = 16'h1000 + 16'(i);
        push_exp(8'hFF, d);
        for (int i = 0; i < 8; i++) send(3'(i), 16'h1000 + 16'(i), 1'b0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_mask", {24'd0, out_mask}, 32'hFF);
        release_frame();
        check("full_cnt_after", {24'd0, frame_cnt}, 32'd1);
        check("full_mask_after", {24'd0, out_mask}, 32'd0);
        check("full_valid_after", {31'd0, out_valid}, 32'd0);

        // Early last, then held under backpressure with in_valid asserted.
        d = '0;
        d[3] = 16'hBEEF;
        d[5] = 16'h1234;
        push_exp(8'h28, d);
        send(3'd3, 16'hBEEF, 1'b0);
        send(3'd5, 16'h1234, 1'b1);
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_mask", {24'd0, out_mask}, 32'h28);
            check("bp_out3", {16'd0, out3}, 32'hBEEF);
            check("bp_out0_stale", {16'd0, out0}, 32'h1000);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("rel_no_accept_mask", {24'd0, out_mask}, 32'd0);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rel_next_accept_mask", {24'd0, out_mask}, 32'h01);
        check("rel_next_accept_out0", {16'd0, out0}, 32'hFFFF);
        d = '0;
        d[0] = 16'hFFFF;
        d[1] = 16'h0001;
        push_exp(8'h03, d);
        send(3'd1, 16'h0001, 1'b1);
        release_frame();
        check("cnt_after_three", {24'd0, frame_cnt}, 32'd3);

        // Duplicate lane write.
        send(3'd2, 16'hAAAA, 1'b0);
        check("dup_first_write", {31'd0, out_dup}, 32'd0);
        send(3'd2, 16'h5555, 1'b0);
        check("dup_pulse", {31'd0, out_dup}, 32'd1);
        check("dup_out2", {16'd0, out2}, 32'h5555);
        check("dup_mask", {24'd0, out_mask}, 32'h04);
        check("dup_stays_fill", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("dup_pulse_end", {31'd0, out_dup}, 32'd0);
        d = '0;
        d[2] = 16'h5555;
        d[7] = 16'h7777;
        push_exp(8'h84, d);
        send(3'd7, 16'h7777, 1'b1);
        release_frame();

        // Reset during a 4-lane partial frame.
        for (int i = 0; i < 4; i++) send(3'(i), 16'h2000 + 16'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mask", {24'd0, out_mask}, 32'd0);
        check("mid_rst_cnt", {24'd0, frame_cnt}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out0", {16'd0, out0}, 32'd0);
        check("mid_rst_queue_empty", exp_q.size(), 32'd0);
        tb_cnt = '0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 256 single-word frames wrap the counter.
        for (int k = 0; k < 256; k++) begin
            d = '0;
            d[k % 8] = 16'(k);
            push_exp(8'(1 << (k % 8)), d);
            send(3'(k % 8), 16'(k), 1'b1);
            if (k == 255) check("wrap_cnt_255", {24'd0, frame_cnt}, 32'd255);
            release_frame();
        end
        check("wrap_cnt_zero", {24'd0, frame_cnt}, 32'd0);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
